// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: steps FETCH/DECODE/EXEC/MEM/WB and drives shared-datapath controls.
// 2-5 cycles per instruction; FETCH/MEMRD/MEMWR stall on mem_ready_i when MEM_WAIT=1.
module multi_cycle_ctrl #(
  parameter int ALUOP_W  = 3,
  parameter int MEM_WAIT = 1,
  parameter int TRAP_EN  = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [5:0]         instr_op_i,
  input  logic               mem_ready_i,
  output logic               PCWrite_o,
  output logic               PCWriteCond_o,
  output logic               IorD_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               IRWrite_o,
  output logic               MemtoReg_o,
  output logic               RegDst_o,
  output logic               RegWrite_o,
  output logic               ALUSrcA_o,
  output logic [1:0]         ALUSrcB_o,
  output logic [1:0]         PCSource_o,
  output logic [ALUOP_W-1:0] ALU_op_o,
  output logic [3:0]         state_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   instr_cnt_o
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_RWB    = 4'd8,  S_BRANCH = 4'd9, S_IEXEC  = 4'd10, S_IWB    = 4'd11,
    S_JUMP   = 4'd12, S_TRAP  = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy;

  assign rdy         = (MEM_WAIT != 0) ? mem_ready_i : 1'b1;
  assign state_o     = state_q;
  assign instr_cnt_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    PCSource_o    = 2'b00;
    ALU_op_o      = '0;
    illegal_o     = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        IRWrite_o = rdy;
        PCWrite_o = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB_o = 2'b11;
        case (instr_op_i)
          OP_R:            state_d = S_EXEC;
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_BEQ:          state_d = S_BRANCH;
          OP_ADDI, OP_SLTI: state_d = S_IEXEC;
          OP_J:            state_d = S_JUMP;
          default:         state_d = (TRAP_EN != 0) ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        state_d   = (instr_op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA_o     = 1'b1;
        ALU_op_o[2:0] = 3'b010;
        state_d       = S_RWB;
      end
      S_RWB: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALU_op_o[2:0] = 3'b001;
        PCWriteCond_o = 1'b1;
        PCSource_o    = 2'b01;
        state_d       = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA_o     = 1'b1;
        ALUSrcB_o     = 2'b10;
        ALU_op_o[2:0] = (instr_op_i == OP_SLTI) ? 3'b011 : 3'b000;
        state_d       = S_IWB;
      end
      S_IWB: begin
        RegWrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCWrite_o  = 1'b1;
        PCSource_o = 2'b10;
        state_d    = S_FETCH;
      end
      S_TRAP: illegal_o = 1'b1;
      default: state_d = S_RST;
    endcase
    // An instruction retires on every return to FETCH, except the start-up step out of RST.
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_RST)
      cnt_d = cnt_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench: dut 0 uses defaults, dut 1 has MEM_WAIT=0, TRAP_EN=0, CNT_W=4.
// Stimulus pushes one expected output vector per cycle; a negedge monitor pops and compares.
module tb_multi_cycle_ctrl;

  localparam int RST = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6;
  localparam int EXEC = 7, RWB = 8, BRANCH = 9, IEXEC = 10, IWB = 11, JUMP = 12, TRAP = 13;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J = 6'b000010, OP_ILL = 6'b111111;

  typedef struct {
    bit          sel;
    logic [37:0] vec;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, rdy_a = 1'b0, rst_b = 1'b0, rdy_b = 1'b0;
  logic [5:0] op_a = '0, op_b = '0;

  logic       pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, srca_a, ill_a;
  logic [1:0] srcb_a, pcsrc_a;
  logic [2:0] alu_a;
  logic [3:0] st_a;
  logic [15:0] cnt_a;
  logic       pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, srca_b, ill_b;
  logic [1:0] srcb_b, pcsrc_b;
  logic [2:0] alu_b;
  logic [3:0] st_b;
  logic [3:0] cnt_b;

  multi_cycle_ctrl u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .instr_op_i(op_a), .mem_ready_i(rdy_a),
    .PCWrite_o(pcw_a), .PCWriteCond_o(pcwc_a), .IorD_o(iord_a), .MemRead_o(mrd_a),
    .MemWrite_o(mwr_a), .IRWrite_o(irw_a), .MemtoReg_o(m2r_a), .RegDst_o(rdst_a),
    .RegWrite_o(rw_a), .ALUSrcA_o(srca_a), .ALUSrcB_o(srcb_a), .PCSource_o(pcsrc_a),
    .ALU_op_o(alu_a), .state_o(st_a), .illegal_o(ill_a), .instr_cnt_o(cnt_a)
  );

  multi_cycle_ctrl #(.ALUOP_W(3), .MEM_WAIT(0), .TRAP_EN(0), .CNT_W(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .instr_op_i(op_b), .mem_ready_i(rdy_b),
    .PCWrite_o(pcw_b), .PCWriteCond_o(pcwc_b), .IorD_o(iord_b), .MemRead_o(mrd_b),
    .MemWrite_o(mwr_b), .IRWrite_o(irw_b), .MemtoReg_o(m2r_b), .RegDst_o(rdst_b),
    .RegWrite_o(rw_b), .ALUSrcA_o(srca_b), .ALUSrcB_o(srcb_b), .PCSource_o(pcsrc_b),
    .ALU_op_o(alu_b), .state_o(st_b), .illegal_o(ill_b), .instr_cnt_o(cnt_b)
  );

  logic [37:0] act_a, act_b;
  assign act_a = {st_a, pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, srca_a,
                  srcb_a, pcsrc_a, alu_a, ill_a, cnt_a};
  assign act_b = {st_b, pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, srca_b,
                  srcb_b, pcsrc_b, alu_b, ill_b, 12'h000, cnt_b};

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cnt_exp[2];

  // Expected control word for one cycle, straight from the per-state output table.
  function automatic logic [37:0] exp_vec(input int st, input bit rdy, input logic [5:0] op,
                                          input int cnt, input int cw);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
    logic [1:0] srcb, pcsrc;
    logic [2:0] alu;
    logic [15:0] c;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill} = '0;
    srcb = 2'b00; pcsrc = 2'b00; alu = 3'b000;
    c = 16'(cnt % (1 << cw));
    case (st)
      FETCH:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      DECODE: srcb = 2'b11;
      MEMADR: begin srca = 1; srcb = 2'b10; end
      MEMRD:  begin mrd = 1; iord = 1; end
      MEMWB:  begin rw = 1; m2r = 1; end
      MEMWR:  begin mwr = 1; iord = 1; end
      EXEC:   begin srca = 1; alu = 3'b010; end
      RWB:    begin rw = 1; rdst = 1; end
      BRANCH: begin srca = 1; alu = 3'b001; pcwc = 1; pcsrc = 2'b01; end
      IEXEC:  begin srca = 1; srcb = 2'b10; alu = (op == OP_SLTI) ? 3'b011 : 3'b000; end
      IWB:    rw = 1;
      JUMP:   begin pcw = 1; pcsrc = 2'b10; end
      TRAP:   ill = 1;
      default: ;
    endcase
    return {4'(st), pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcsrc, alu, ill, c};
  endfunction

  // Drive one cycle's inputs (just after the edge) and queue what the DUT must show this cycle.
  task automatic cyc(input bit sel, input bit rst, input logic [5:0] op, input bit rdy,
                     input int st, input string name);
    exp_t e;
    if (sel == 1'b0) begin rst_a = rst; op_a = op; rdy_a = rdy; end
    else             begin rst_b = rst; op_b = op; rdy_b = rdy; end
    if (!rst) cnt_exp[sel] = 0;
    e.sel  = sel;
    e.name = name;
    e.vec  = exp_vec(st, sel ? 1'b1 : rdy, op, cnt_exp[sel], sel ? 4 : 16);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input bit sel, input logic [5:0] op, input int fwait, input int mwait,
                     input bit lo, input string name);
    bit r;
    r = !lo;
    repeat (fwait) cyc(sel, 1, op, 0, FETCH, name);
    cyc(sel, 1, op, r, FETCH, name);
    cyc(sel, 1, op, r, DECODE, name);
    case (op)
      OP_R:    begin cyc(sel, 1, op, r, EXEC, name); cyc(sel, 1, op, r, RWB, name); end
      OP_LW: begin
        cyc(sel, 1, op, r, MEMADR, name);
        repeat (mwait) cyc(sel, 1, op, 0, MEMRD, name);
        cyc(sel, 1, op, r, MEMRD, name);
        cyc(sel, 1, op, r, MEMWB, name);
      end
      OP_SW: begin
        cyc(sel, 1, op, r, MEMADR, name);
        repeat (mwait) cyc(sel, 1, op, 0, MEMWR, name);
        cyc(sel, 1, op, r, MEMWR, name);
      end
      OP_BEQ:           cyc(sel, 1, op, r, BRANCH, name);
      OP_ADDI, OP_SLTI: begin cyc(sel, 1, op, r, IEXEC, name); cyc(sel, 1, op, r, IWB, name); end
      OP_J:             cyc(sel, 1, op, r, JUMP, name);
      default: ;
    endcase
    cnt_exp[sel] = cnt_exp[sel] + 1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [37:0] act;
      e   = sb.pop_front();
      act = e.sel ? act_b : act_a;
      n_vec++;
      if (act !== e.vec) begin
        n_err++;
        $display("FAIL %s dut%0d t=%0t: got %h want %h", e.name, e.sel, $time, act, e.vec);
      end
    end
  end

  initial begin
    cnt_exp[0] = 0;
    cnt_exp[1] = 0;
    @(posedge clk);
    #1;
    // dut 0: reset state, then each instruction class
    cyc(0, 0, OP_R, 1, RST, "a_reset");
    cyc(0, 0, OP_R, 1, RST, "a_reset");
    cyc(0, 1, OP_R, 1, RST, "a_release");
    run(0, OP_R,    0, 0, 0, "a_rtype");
    run(0, OP_LW,   0, 2, 0, "a_lw_wait");
    run(0, OP_SW,   0, 1, 0, "a_sw_wait");
    run(0, OP_BEQ,  0, 0, 0, "a_beq");
    run(0, OP_ADDI, 0, 0, 0, "a_addi");
    run(0, OP_SLTI, 0, 0, 0, "a_slti");
    run(0, OP_J,    3, 0, 0, "a_j_fetchwait");
    // illegal opcode traps and holds regardless of mem_ready_i
    cyc(0, 1, OP_ILL, 1, FETCH, "a_ill");
    cyc(0, 1, OP_ILL, 1, DECODE, "a_ill");
    for (int i = 0; i < 12; i++) cyc(0, 1, OP_ILL, i[0], TRAP, "a_trap_hold");
    cyc(0, 0, OP_ILL, 1, RST, "a_trap_clear");
    cyc(0, 1, OP_R, 1, RST, "a_release2");
    run(0, OP_J, 0, 0, 0, "a_j");
    // asynchronous abort in EXEC: checked mid-cycle, before any clock edge
    cyc(0, 1, OP_R, 1, FETCH, "a_abort");
    cyc(0, 1, OP_R, 1, DECODE, "a_abort");
    cyc(0, 1, OP_R, 1, EXEC, "a_abort");
    cyc(0, 0, OP_R, 1, RST, "a_async_rst");
    cyc(0, 0, OP_R, 1, RST, "a_held_rst");

    // dut 1: no memory wait, illegal as NOP, 4-bit counter
    cyc(1, 0, OP_J, 0, RST, "b_reset");
    cyc(1, 1, OP_J, 0, RST, "b_release");
    for (int i = 0; i < 17; i++) run(1, OP_J, 0, 0, 1, "b_j_wrap");
    run(1, OP_ILL, 0, 0, 1, "b_ill_nop");
    run(1, OP_LW,  0, 0, 1, "b_lw_nowait");
    run(1, OP_SW,  0, 0, 1, "b_sw_nowait");
    cyc(1, 1, OP_R, 0, FETCH, "b_final");

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
